// File: rtl/led_seq_master.sv
`default_nettype none
// ============================================================================
// Module   : led_seq_master
// Brief    : Autonomous bus master that steps an 8-bit LED pattern, writes
//            each step to the LED data register and optionally reads it back
//            from the status register to detect mismatches.
// Revision : 1.0 - initial release
// ============================================================================
module led_seq_master #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          PERIOD_W  = 24,
    parameter bit          VERIFY    = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic [1:0]          mode_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                busy_o,
    output logic                err_o,
    output logic [7:0]          pattern_o,
    output logic                bus_req_o,
    input  logic                bus_gnt_i,
    output logic                wr_en_o,
    output logic                rd_en_o,
    output logic [31:0]         addr_o,
    output logic [31:0]         data_o,
    input  logic [31:0]         data_i
);

    localparam logic [PERIOD_W-1:0] PERIOD_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]         DATA_ADDR  = BASE_ADDR;
    localparam logic [31:0]         STAT_ADDR  = BASE_ADDR + 32'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_DONE  = 3'd4,
        S_WAIT  = 3'd5
    } state_t;

    state_t                state_q,   state_d;
    logic [1:0]            mode_q,    mode_d;
    logic [PERIOD_W-1:0]   period_q,  period_d;
    logic [PERIOD_W-1:0]   cnt_q,     cnt_d;
    logic [7:0]            pat_q,     pat_d;
    logic                  dir_q,     dir_d;      // bounce direction, 1 = moving down
    logic [7:0]            pat_out_q, pat_out_d;
    logic                  err_q,     err_d;
    logic                  stop_q,    stop_d;     // stop seen mid-transaction

    logic [7:0]            next_pat;
    logic                  next_dir;
    logic [7:0]            init_pat;

    // Next-step pattern for the currently latched mode
    always_comb begin
        next_pat = pat_q;
        next_dir = dir_q;
        case (mode_q)
            2'd0: next_pat = {pat_q[6:0], pat_q[7]};
            2'd1: begin
                if (!dir_q) begin
                    if (pat_q == 8'h80) begin
                        next_pat = 8'h40;
                        next_dir = 1'b1;
                    end else begin
                        next_pat = {pat_q[6:0], 1'b0};
                    end
                end else begin
                    if (pat_q == 8'h01) begin
                        next_pat = 8'h02;
                        next_dir = 1'b0;
                    end else begin
                        next_pat = {1'b0, pat_q[7:1]};
                    end
                end
            end
            2'd2: next_pat = ~pat_q;
            default: next_pat = pat_q + 8'd1;
        endcase
    end

    // First pattern for the mode being requested at start
    always_comb begin
        case (mode_i)
            2'd2:    init_pat = 8'hFF;
            2'd3:    init_pat = 8'h00;
            default: init_pat = 8'h01;
        endcase
    end

    // Sequencer next-state and bus outputs
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        period_d  = period_q;
        cnt_d     = cnt_q;
        pat_d     = pat_q;
        dir_d     = dir_q;
        pat_out_d = pat_out_q;
        err_d     = err_q;
        stop_d    = stop_q;
        bus_req_o = 1'b0;
        wr_en_o   = 1'b0;
        rd_en_o   = 1'b0;
        addr_o    = 32'h0;
        data_o    = 32'h0;

        case (state_q)
            S_IDLE: begin
                // A simultaneous stop cancels the start outright.
                if (start_i && !stop_i) begin
                    mode_d   = mode_i;
                    period_d = (period_i == '0) ? PERIOD_ONE : period_i;
                    pat_d    = init_pat;
                    dir_d    = 1'b0;
                    err_d    = 1'b0;
                    stop_d   = 1'b0;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                bus_req_o = 1'b1;
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (bus_gnt_i) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                bus_req_o = 1'b1;
                wr_en_o   = 1'b1;
                addr_o    = DATA_ADDR;
                data_o    = {24'h0, pat_q};
                pat_out_d = pat_q;
                if (stop_i) begin
                    stop_d = 1'b1;
                end
                state_d = VERIFY ? S_READ : S_DONE;
            end
            S_READ: begin
                bus_req_o = 1'b1;
                rd_en_o   = 1'b1;
                addr_o    = STAT_ADDR;
                if (data_i != {24'h0, pat_q}) begin
                    err_d = 1'b1;
                end
                if (stop_i) begin
                    stop_d = 1'b1;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                pat_d   = next_pat;
                dir_d   = next_dir;
                cnt_d   = period_q;
                state_d = (stop_q || stop_i) ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q <= PERIOD_ONE) begin
                    state_d = S_REQ;
                end else begin
                    cnt_d = cnt_q - PERIOD_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= 2'd0;
            period_q  <= '0;
            cnt_q     <= '0;
            pat_q     <= 8'h00;
            dir_q     <= 1'b0;
            pat_out_q <= 8'h00;
            err_q     <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            pat_q     <= pat_d;
            dir_q     <= dir_d;
            pat_out_q <= pat_out_d;
            err_q     <= err_d;
            stop_q    <= stop_d;
        end
    end

    assign busy_o    = (state_q != S_IDLE);
    assign err_o     = err_q & VERIFY;
    assign pattern_o = pat_out_q;

endmodule
`default_nettype wire

// File: tb/tb_led_seq_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_seq_master
// Brief    : Directed self-checking bench for led_seq_master with a simple
//            LED peripheral model that can corrupt its readback.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_seq_master;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, stop_i;
    logic [1:0]  mode_i;
    logic [23:0] period_i;
    logic        busy_o, err_o;
    logic [7:0]  pattern_o;
    logic        bus_req_o, bus_gnt_i;
    logic        wr_en_o, rd_en_o;
    logic [31:0] addr_o, data_o, data_i;

    logic        corrupt;
    logic [7:0]  periph_q;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] wdata [32];
    int          wcyc  [32];
    int          wcount;
    int          addr_bad;
    int          rd_bad;

    led_seq_master #(
        .BASE_ADDR (BASE),
        .PERIOD_W  (24),
        .VERIFY    (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .mode_i    (mode_i),
        .period_i  (period_i),
        .busy_o    (busy_o),
        .err_o     (err_o),
        .pattern_o (pattern_o),
        .bus_req_o (bus_req_o),
        .bus_gnt_i (bus_gnt_i),
        .wr_en_o   (wr_en_o),
        .rd_en_o   (rd_en_o),
        .addr_o    (addr_o),
        .data_o    (data_o),
        .data_i    (data_i)
    );

    always #5 clk = ~clk;

    // Cycle counter used to measure write spacing
    always @(posedge clk) cyc <= cyc + 1;

    // LED peripheral: status register mirrors the last write
    always @(posedge clk or posedge rst) begin
        if (rst) periph_q <= 8'h00;
        else if (wr_en_o) periph_q <= data_o[7:0];
    end
    assign data_i = corrupt ? 32'h0 : {24'h0, periph_q};

    task automatic pulse_start(input logic [1:0] m, input logic [23:0] p);
        @(negedge clk);
        mode_i   = m;
        period_i = p;
        start_i  = 1'b1;
        @(negedge clk);
        start_i  = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_wr(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (wr_en_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rd(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (rd_en_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Records n writes (data, cycle) and tallies bad addresses and missing reads
    task automatic collect_writes(input int n, input int budget);
        bit prev_wr = 1'b0;
        wcount   = 0;
        addr_bad = 0;
        rd_bad   = 0;
        for (int c = 0; c < budget && wcount < n; c++) begin
            @(negedge clk);
            if (prev_wr && !(rd_en_o && !wr_en_o && addr_o == BASE + 32'd4)) rd_bad++;
            prev_wr = wr_en_o;
            if (wr_en_o) begin
                if (addr_o != BASE) addr_bad++;
                wdata[wcount] = data_o;
                wcyc[wcount]  = cyc;
                wcount++;
            end
        end
        if (prev_wr) begin
            @(negedge clk);
            if (!(rd_en_o && addr_o == BASE + 32'd4)) rd_bad++;
        end
    endtask

    task automatic stop_and_idle(input string name);
        bit ok;
        pulse_stop();
        wait_idle(20, ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_idle: busy_o=%b, required 0 within 20 cycles", name, busy_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 0; stop_i = 0; mode_i = 0; period_i = 0;
        bus_gnt_i = 0; corrupt = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy_o, err_o, pattern_o, bus_req_o, wr_en_o, rd_en_o, addr_o, data_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b err=%b pat=%h req=%b wr=%b rd=%b addr=%h data=%h, required all 0",
                     busy_o, err_o, pattern_o, bus_req_o, wr_en_o, rd_en_o, addr_o, data_o);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy_o, bus_req_o, wr_en_o, rd_en_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: busy=%b req=%b wr=%b rd=%b, required 0",
                     busy_o, bus_req_o, wr_en_o, rd_en_o);
        end
    endtask

    task automatic test_walking();
        logic [7:0] exp_w [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        int bad_gap = 0;
        bus_gnt_i = 1'b1;
        pulse_start(2'd0, 24'd3);
        collect_writes(9, 120);
        n_checks++;
        if (wcount != 9) begin
            n_fail++;
            $display("FAIL walk_count: got %0d writes, required 9", wcount);
        end
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (wdata[i] !== {24'h0, exp_w[i]}) begin
                n_fail++;
                $display("FAIL walk_data[%0d]: got %h, required %h", i, wdata[i], {24'h0, exp_w[i]});
            end
        end
        for (int i = 0; i < 8; i++) if (wcyc[i+1] - wcyc[i] != 7) bad_gap++;
        n_checks++;
        if (bad_gap != 0 || addr_bad != 0 || rd_bad != 0) begin
            n_fail++;
            $display("FAIL walk_timing: bad_gaps=%0d bad_addr=%0d missing_reads=%0d, required 0/0/0",
                     bad_gap, addr_bad, rd_bad);
        end
        n_checks++;
        if (err_o !== 1'b0 || pattern_o !== 8'h01) begin
            n_fail++;
            $display("FAIL walk_status: err=%b pattern_o=%h, required 0 and 01", err_o, pattern_o);
        end
        stop_and_idle("walk");
    endtask

    task automatic test_bounce();
        logic [7:0] exp_b [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                   8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        int bad_gap = 0;
        bus_gnt_i = 1'b1;
        pulse_start(2'd1, 24'd0);
        collect_writes(16, 150);
        n_checks++;
        if (wcount != 16) begin
            n_fail++;
            $display("FAIL bounce_count: got %0d writes, required 16", wcount);
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (wdata[i] !== {24'h0, exp_b[i]}) begin
                n_fail++;
                $display("FAIL bounce_data[%0d]: got %h, required %h", i, wdata[i], {24'h0, exp_b[i]});
            end
        end
        for (int i = 0; i < 15; i++) if (wcyc[i+1] - wcyc[i] != 5) bad_gap++;
        n_checks++;
        if (bad_gap != 0 || rd_bad != 0) begin
            n_fail++;
            $display("FAIL bounce_timing: bad_gaps=%0d missing_reads=%0d, required 0/0", bad_gap, rd_bad);
        end
        stop_and_idle("bounce");
    endtask

    task automatic test_grant_stall();
        int bad = 0;
        bus_gnt_i = 1'b0;
        pulse_start(2'd0, 24'd4);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            if (!(bus_req_o && busy_o && !wr_en_o && !rd_en_o)) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_req: %0d of 10 cycles without req-only, required 0", bad);
        end
        bus_gnt_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (!(wr_en_o && !rd_en_o && bus_req_o && addr_o == BASE && data_o == 32'h01)) begin
            n_fail++;
            $display("FAIL stall_write: wr=%b rd=%b req=%b addr=%h data=%h, required 1 0 1 %h 00000001",
                     wr_en_o, rd_en_o, bus_req_o, addr_o, data_o, BASE);
        end
        bus_gnt_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (!(rd_en_o && !wr_en_o && bus_req_o && addr_o == BASE + 32'd4)) begin
            n_fail++;
            $display("FAIL stall_read: wr=%b rd=%b req=%b addr=%h, required 0 1 1 %h",
                     wr_en_o, rd_en_o, bus_req_o, addr_o, BASE + 32'd4);
        end
        @(negedge clk);
        n_checks++;
        if (bus_req_o || wr_en_o || rd_en_o || addr_o != 32'h0 || !busy_o) begin
            n_fail++;
            $display("FAIL stall_done: req=%b wr=%b rd=%b addr=%h busy=%b, required 0 0 0 0 1",
                     bus_req_o, wr_en_o, rd_en_o, addr_o, busy_o);
        end
        stop_and_idle("stall");
    endtask

    task automatic test_readback_error();
        bit ok;
        bus_gnt_i = 1'b1;
        corrupt   = 1'b1;
        pulse_start(2'd2, 24'd2);
        wait_rd(20, ok);
        n_checks++;
        if (ok !== 1'b1 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL err_before: read_seen=%b err=%b, required 1 and 0", ok, err_o);
        end
        @(negedge clk);
        corrupt = 1'b0;
        n_checks++;
        if (err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: err=%b, required 1", err_o);
        end
        collect_writes(2, 40);
        n_checks++;
        if (wcount != 2 || wdata[0] !== 32'h00 || wdata[1] !== 32'hFF || err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: writes=%0d d0=%h d1=%h err=%b, required 2 00 FF 1",
                     wcount, wdata[0], wdata[1], err_o);
        end
        stop_and_idle("err");
        // start and stop together: stays idle, error flag untouched
        @(negedge clk);
        mode_i = 2'd0; period_i = 24'd1; start_i = 1'b1; stop_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; stop_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || bus_req_o !== 1'b0 || err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL start_stop_idle: busy=%b req=%b err=%b, required 0 0 1", busy_o, bus_req_o, err_o);
        end
        pulse_start(2'd0, 24'd3);
        n_checks++;
        if (err_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL err_clear: err=%b busy=%b, required 0 1", err_o, busy_o);
        end
        stop_and_idle("err_clear");
    endtask

    task automatic test_stop();
        bit ok;
        int act = 0;
        bus_gnt_i = 1'b1;
        pulse_start(2'd0, 24'd5);
        wait_wr(20, ok);
        repeat (3) @(negedge clk);   // READ, DONE, then first WAIT cycle
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        n_checks++;
        if (ok !== 1'b1 || busy_o !== 1'b0 || bus_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_wait: write_seen=%b busy=%b req=%b, required 1 0 0", ok, busy_o, bus_req_o);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy_o || wr_en_o || rd_en_o || bus_req_o) act++;
        end
        n_checks++;
        if (act != 0) begin
            n_fail++;
            $display("FAIL stop_wait_quiet: %0d active cycles, required 0", act);
        end
        pulse_start(2'd0, 24'd5);
        wait_wr(20, ok);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        n_checks++;
        if (ok !== 1'b1 || rd_en_o !== 1'b1 || addr_o !== BASE + 32'd4) begin
            n_fail++;
            $display("FAIL stop_write_read: write_seen=%b rd=%b addr=%h, required 1 1 %h",
                     ok, rd_en_o, addr_o, BASE + 32'd4);
        end
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b1 || bus_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_write_done: busy=%b req=%b, required 1 0", busy_o, bus_req_o);
        end
        act = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy_o || wr_en_o || rd_en_o || bus_req_o) act++;
        end
        n_checks++;
        if (act != 0) begin
            n_fail++;
            $display("FAIL stop_write_idle: %0d active cycles, required 0", act);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        int act = 0;
        bus_gnt_i = 1'b1;
        corrupt   = 1'b1;
        pulse_start(2'd0, 24'd1);
        wait_rd(20, ok);
        @(negedge clk);
        corrupt = 1'b0;
        wait_rd(20, ok);
        n_checks++;
        if (ok !== 1'b1 || err_o !== 1'b1 || pattern_o !== 8'h02) begin
            n_fail++;
            $display("FAIL rst_setup: read_seen=%b err=%b pattern_o=%h, required 1 1 02", ok, err_o, pattern_o);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus_req_o, rd_en_o, busy_o, err_o, pattern_o, addr_o} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: req=%b rd=%b busy=%b err=%b pat=%h addr=%h, required all 0",
                     bus_req_o, rd_en_o, busy_o, err_o, pattern_o, addr_o);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy_o || wr_en_o || rd_en_o || bus_req_o) act++;
        end
        n_checks++;
        if (act != 0) begin
            n_fail++;
            $display("FAIL rst_quiet: %0d active cycles, required 0", act);
        end
        pulse_start(2'd3, 24'd1);
        collect_writes(2, 30);
        n_checks++;
        if (wcount != 2 || wdata[0] !== 32'h00 || wdata[1] !== 32'h01 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_restart: writes=%0d d0=%h d1=%h err=%b, required 2 00 01 0",
                     wcount, wdata[0], wdata[1], err_o);
        end
        stop_and_idle("restart");
    endtask

    initial begin
        test_reset();
        test_walking();
        test_bounce();
        test_grant_stall();
        test_readback_error();
        test_stop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/led_seq_master.md
Name: led_seq_master

Overview:
- Autonomous bus master that animates the LED peripheral without CPU involvement.
- Generates one of four 8-bit LED patterns, one step every programmed number of cycles.
- Each step is written to the peripheral's data register (offset 0x0), then read back from its status register (offset 0x4) to check it.
- Sits on the peripheral bus beside the processor; gains bus access through a req/gnt handshake with the bus arbiter.

Parameters:
BASE_ADDR, 32'h8000_0000, LED peripheral base address; write goes to BASE_ADDR+0x0, readback to BASE_ADDR+0x4
PERIOD_W, 24, width of the step-period counter
VERIFY, 1, 1 = readback compare enabled; 0 = READ state skipped, err_o held 0

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start_i  in  1  one-cycle pulse; begins a sequence when idle
stop_i  in  1  one-cycle pulse; ends the sequence
mode_i  in  2  pattern select, latched at start
period_i  in  PERIOD_W  cycles between steps, latched at start
busy_o  out  1  high whenever state != IDLE
err_o  out  1  sticky readback-mismatch flag
pattern_o  out  8  pattern of the most recently issued write
bus_req_o  out  1  bus request to arbiter
bus_gnt_i  in  1  bus grant from arbiter
wr_en_o  out  1  peripheral write strobe
rd_en_o  out  1  peripheral read strobe
addr_o  out  32  peripheral address
data_o  out  32  write data, {24'b0, pattern}
data_i  in  32  read data; combinational, valid in the same cycle as rd_en_o

Behaviour:
- Reset (asynchronous, active-high) forces the following, regardless of state; the bus is released immediately:
  - state = IDLE
  - all outputs = 0
  - internal pattern = 0
- Period: P = latched period_i, with 0 treated as 1.
- Pattern modes (next-step value):
  - 0 walking-one: 01→02→…→80→01.
  - 1 bounce: 01→02→…→80→40→…→01→02…; direction flips at 80 and 01.
  - 2 blink: FF↔00.
  - 3 count: +1 modulo 256 (FF→00).
- Initial pattern per mode: 01, 01 (direction up), FF, 00.
- State machine, one state per cycle unless stated:
  - IDLE:
    - start_i=1 and stop_i=0: latch mode and period, load the initial pattern, clear err_o, go REQ.
    - start_i=1 and stop_i=1 in the same cycle: stop wins; remain IDLE with err_o unchanged.
  - REQ: bus_req_o=1; hold until bus_gnt_i=1, then go WRITE.
  - WRITE (1 cycle):
    - bus_req_o=1, wr_en_o=1, addr_o=BASE_ADDR, data_o={24'b0, pattern}.
    - pattern_o updates to the written pattern on the next edge.
    - Next state: READ if VERIFY, else DONE.
  - READ (1 cycle):
    - bus_req_o=1, rd_en_o=1, addr_o=BASE_ADDR+4.
    - If data_i[7:0] != pattern or data_i[31:8] != 0: set err_o on the next edge.
  - DONE (1 cycle): bus_req_o=0; advance the pattern to its next-step value; load the counter with P; go WAIT.
  - WAIT: decrement the counter; when it reaches 1, go REQ. WAIT lasts exactly P cycles.
- Bus signalling:
  - wr_en_o, rd_en_o and addr_o are 0 outside WRITE and READ.
  - bus_req_o is asserted only in REQ, WRITE and READ.
  - bus_gnt_i is ignored outside REQ; the grant is assumed held through WRITE and READ.
- stop_i handling:
  - In WAIT or REQ: go IDLE on the next edge, with bus_req_o dropping at that edge.
  - In WRITE, READ or DONE: the stop is recorded; the transaction completes, then DONE goes to IDLE instead of WAIT.
- start_i while busy is ignored.
- err_o stays high until the next accepted start or a reset.
- Step-to-step spacing with immediate grant: 1 (REQ) + 1 (WRITE) + VERIFY + 1 (DONE) + P cycles.

Test Plan:
1. Grant tied high, mode=0, period=3, start → writes at BASE+0 with data 01, 02, 04, …, 80, 01. Each write is followed the next cycle by rd_en_o at BASE+4. Writes are 7 cycles apart. err_o stays 0 with a correctly modelled peripheral.
2. mode=1, period=0 (treated as 1) → write data sequence 01,02,…,80,40,…,01,02. Writes are 5 cycles apart. No pattern value is repeated at the turnaround points.
3. Grant withheld for 10 cycles in REQ → bus_req_o held high, no strobes issued. After the grant, exactly one WRITE then one READ occur, then bus_req_o drops.
4. Peripheral model returns 0x0000_0000 on the first readback, with mode=2 (first pattern FF) → err_o=1 from the cycle after READ, held through later steps. err_o clears on the next start.
5. stop_i during WAIT → busy_o=0 the next cycle, no further strobes. stop_i during WRITE → the READ still occurs, then IDLE. start_i and stop_i together in IDLE → stays IDLE.
6. rst asserted during READ → bus_req_o, rd_en_o, busy_o, pattern_o and err_o all 0 immediately (asynchronously). After release, no activity until start_i.
